// File: rtl/d2l_tx_scheduler_if.sv
// rtl/d2l_tx_scheduler_if.sv - request stream and response bundle for d2l_tx_scheduler
interface d2l_tx_scheduler_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_width;
  logic [63:0] in_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;

  modport master (
    output in_valid, in_width, in_data,
    input  in_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  in_valid, in_width, in_data,
    output in_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/d2l_tx_scheduler.sv
// rtl/d2l_tx_scheduler.sv - FIFO-fed single-shot launcher for the D2L link wrapper
// Optional completion timeout compiled in with D2L_TXS_TIMEOUT_EN.
module d2l_tx_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  d2l_tx_scheduler_if.slave   s_req,
  output logic                out_en,
  output logic [70:0]         DATA_IN,
  input  logic                done_in,
  input  logic [63:0]         rx_data,
  output logic                busy,
  output logic                err_width,
  output logic                err_timeout,
  input  logic                err_clr,
  output logic [15:0]         tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
    $error("d2l_tx_scheduler: illegal DEPTH or TIMEOUT");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [70:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [70:0]    r_data_in;
  logic           r_rsp_valid;
  logic [63:0]    r_rsp_data;
  logic [15:0]    r_tx_count;
  logic           r_err_width;

  logic           w_full;
  logic           w_accept;
  logic           w_legal;
  logic           w_push;
  logic           w_pop;
  logic           w_complete;
  logic           w_abort;

  // Ready looks only at the registered count; a same-cycle pop never frees a slot.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_accept = s_req.in_valid && !w_full;
  assign w_legal  = (s_req.in_width != 7'd0) && (s_req.in_width <= 7'd64);
  assign w_push   = w_accept && w_legal;

`ifdef D2L_TXS_TIMEOUT_EN
  logic [15:0] r_wcnt;
  logic        r_err_timeout;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (done_in) begin
          w_complete = 1'b1;
          w_next     = S_IDLE;
        end
`ifdef D2L_TXS_TIMEOUT_EN
        else if (r_wcnt == 16'(TIMEOUT - 1)) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {s_req.in_width, s_req.in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_in   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_pop) r_data_in <= r_mem[r_rptr];
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_data <= rx_data;
        r_tx_count <= r_tx_count + 16'd1;
      end
    end
  end

  // Sticky errors: a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_err_width <= 1'b0;
    else if (w_accept && !w_legal) r_err_width <= 1'b1;
    else if (err_clr)             r_err_width <= 1'b0;
  end

`ifdef D2L_TXS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_wcnt <= '0;
    else if (r_state == S_LAUNCH) r_wcnt <= '0;
    else if (r_state == S_WAIT)   r_wcnt <= r_wcnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_err_timeout <= 1'b0;
    else if (w_abort) r_err_timeout <= 1'b1;
    else if (err_clr) r_err_timeout <= 1'b0;
  end

  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

  assign s_req.in_ready  = !w_full;
  assign s_req.rsp_valid = r_rsp_valid;
  assign s_req.rsp_data  = r_rsp_data;
  assign out_en          = (r_state == S_LAUNCH);
  assign DATA_IN         = r_data_in;
  assign busy            = (r_state != S_IDLE) || (r_count != '0);
  assign err_width       = r_err_width;
  assign tx_count        = r_tx_count;

endmodule
